// File: rtl/udp_pkg.sv
// UDP framing constants, header beat index and FSM encoding.
// Shared by the udp_rx and udp_tx framers.
package udp_pkg;

  localparam int UDP_HEAD_N     = 8;
  localparam int UDP_HEAD_BEATS = 4;
  localparam int PORT_W         = 16;

  localparam logic [PORT_W-1:0] DEFAULT_PORT = 16'd18070;

  typedef enum logic [1:0] {
    SRC  = 2'd0,
    DST  = 2'd1,
    LEN  = 2'd2,
    CSUM = 2'd3
  } head_beat_e;

  typedef enum logic [2:0] {
    IDLE = 3'b001,
    HEAD = 3'b010,
    DATA = 3'b100
  } state_e;

endpackage

// File: rtl/udp_tx.sv
// UDP transmit framer: emits the 4-beat UDP header, then passes the payload.
// Ports: clk/nreset, cancel_i, app side (valid_i,start_i,data_i,len_i,plen_i,
// ready_o), IP side (ready_i,valid_o,start_o,last_o,data_o,len_o), udp_len_o.
module udp_tx #(
  parameter int                DATA_W   = 16,
  parameter int                LEN_W    = 2,
  parameter int                PORT_W   = 16,
  parameter logic [PORT_W-1:0] SRC_PORT = udp_pkg::DEFAULT_PORT,
  parameter logic [PORT_W-1:0] DST_PORT = udp_pkg::DEFAULT_PORT,
  parameter int                CNT_W    = 16
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              cancel_i,
  input  logic              valid_i,
  input  logic              start_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [LEN_W-1:0]  len_i,
  input  logic [CNT_W-1:0]  plen_i,
  output logic              ready_o,
  input  logic              ready_i,
  output logic              valid_o,
  output logic              start_o,
  output logic              last_o,
  output logic [DATA_W-1:0] data_o,
  output logic [LEN_W-1:0]  len_o,
  output logic [CNT_W-1:0]  udp_len_o
);

  import udp_pkg::*;

  state_e           state_q, state_d;
  head_beat_e       h_q, h_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] plen_q, plen_d;
  logic [CNT_W-1:0] ulen_q, ulen_d;
  logic [CNT_W-1:0] cnt_nx;
  logic [CNT_W-1:0] tail;

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_q <= IDLE;
      h_q     <= SRC;
      cnt_q   <= '0;
      plen_q  <= '0;
      ulen_q  <= '0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      cnt_q   <= cnt_d;
      plen_q  <= plen_d;
      ulen_q  <= ulen_d;
    end
  end

  assign cnt_nx    = cnt_q + CNT_W'(len_i);
  assign tail      = plen_q - cnt_q;
  assign udp_len_o = ulen_q;

  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    cnt_d   = cnt_q;
    plen_d  = plen_q;
    ulen_d  = ulen_q;
    valid_o = 1'b0;
    ready_o = 1'b0;
    start_o = 1'b0;
    last_o  = 1'b0;
    data_o  = '0;
    len_o   = '0;

    unique case (1'b1)
      (state_q == IDLE): begin
        if (valid_i && start_i) begin
          plen_d  = plen_i;
          ulen_d  = plen_i + CNT_W'(UDP_HEAD_N);
          h_d     = SRC;
          cnt_d   = '0;
          state_d = HEAD;
        end
      end
      (state_q == HEAD): begin
        valid_o = 1'b1;
        len_o   = LEN_W'(2);
        start_o = (h_q == SRC);
        unique case (h_q)
          SRC:  data_o = DATA_W'(SRC_PORT);
          DST:  data_o = DATA_W'(DST_PORT);
          LEN:  data_o = DATA_W'(ulen_q);
          CSUM: data_o = '0;
        endcase
        if (ready_i) begin
          if (h_q == CSUM) begin
            state_d = DATA;
          end else begin
            h_d = head_beat_e'(h_q + 2'd1);
          end
        end
      end
      (state_q == DATA): begin
        valid_o = valid_i;
        ready_o = ready_i;
        data_o  = data_i;
        last_o  = valid_i && (cnt_nx >= plen_q);
        // Clip an overshooting final beat to the bytes still owed.
        len_o   = last_o ? LEN_W'(tail) : len_i;
        if (valid_i && ready_i) begin
          cnt_d = cnt_nx;
          if (last_o) begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Abort wins over everything, including a start seen in IDLE.
    if (cancel_i) begin
      state_d = IDLE;
      h_d     = SRC;
      cnt_d   = '0;
      plen_d  = plen_q;
      ulen_d  = ulen_q;
      valid_o = 1'b0;
      ready_o = 1'b0;
      start_o = 1'b0;
      last_o  = 1'b0;
    end
  end

  plen_legal: assert property (
    @(posedge clk) disable iff (!nreset)
    (state_q == IDLE && valid_i && start_i && !cancel_i)
      |-> (plen_i != '0 &&
           plen_i <= ({CNT_W{1'b1}} - CNT_W'(UDP_HEAD_N)))
  );

endmodule

// File: tb/tb_udp_tx.sv
// Randomised bench for udp_tx with a frame-level reference model.
// Model expands each accepted start into header + clipped payload beats.
module tb_udp_tx;

  logic        clk = 1'b0;
  logic        nreset = 1'b0;
  logic        cancel_i = 1'b0;
  logic        valid_i = 1'b0;
  logic        start_i = 1'b0;
  logic [15:0] data_i = '0;
  logic [1:0]  len_i = '0;
  logic [15:0] plen_i = '0;
  logic        ready_i = 1'b0;
  logic        ready_o, valid_o, start_o, last_o;
  logic [15:0] data_o, udp_len_o;
  logic [1:0]  len_o;

  udp_tx dut (
    .clk       (clk),
    .nreset    (nreset),
    .cancel_i  (cancel_i),
    .valid_i   (valid_i),
    .start_i   (start_i),
    .data_i    (data_i),
    .len_i     (len_i),
    .plen_i    (plen_i),
    .ready_o   (ready_o),
    .ready_i   (ready_i),
    .valid_o   (valid_o),
    .start_o   (start_o),
    .last_o    (last_o),
    .data_o    (data_o),
    .len_o     (len_o),
    .udp_len_o (udp_len_o)
  );

  always #5 clk = ~clk;

  localparam int PORT = 18070;

  typedef struct {
    logic [15:0] d;
    int          l;
    bit          st;
    bit          la;
    bit          hdr;
    int          hi;
  } beat_t;

  typedef struct {
    logic [15:0] d;
    int          l;
    bit          st;
    bit          la;
    bit          rdy;
  } obs_t;

  beat_t       q[$];
  obs_t        log_q[$];
  int          n_chk = 0;
  int          n_fail = 0;
  logic [15:0] pay_d[64];
  int          pay_l[64];
  bit          ulen_ok = 0;
  int          ulen_exp = 0;
  bit          took = 0;
  int          front_hdr = -1;
  bit          front_pay = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic build(input int plen);
    int    cum;
    beat_t b;
    cum = 0;
    q.delete();
    for (int i = 0; i < 4; i++) begin
      b.hdr = 1;
      b.hi  = i;
      b.st  = (i == 0);
      b.la  = 0;
      b.l   = 2;
      b.d   = (i == 0) ? 16'(PORT) : (i == 1) ? 16'(PORT) :
              (i == 2) ? 16'(plen + 8) : 16'h0000;
      q.push_back(b);
    end
    for (int i = 0; i < 64 && cum < plen; i++) begin
      b.hdr = 0;
      b.hi  = -1;
      b.st  = 0;
      b.d   = pay_d[i];
      b.l   = (plen - cum < pay_l[i]) ? plen - cum : pay_l[i];
      b.la  = (cum + pay_l[i] >= plen);
      cum  += pay_l[i];
      q.push_back(b);
    end
  endtask

  always @(negedge clk) begin
    beat_t       e;
    obs_t        o;
    logic [15:0] ed;
    logic [15:0] ad;
    if (!nreset) begin
      q.delete();
      ulen_ok = 0;
      took = 0;
    end else begin
      if (ulen_ok) chk("udp_len", int'(udp_len_o), ulen_exp);
      took = valid_i && ready_o && !cancel_i;
      if (valid_o) begin
        o.d = data_o; o.l = int'(len_o); o.st = start_o;
        o.la = last_o; o.rdy = ready_o;
        log_q.push_back(o);
      end
      if (cancel_i) begin
        chk("cancel_valid", int'(valid_o), 0);
        chk("cancel_ready", int'(ready_o), 0);
        chk("cancel_last", int'(last_o), 0);
        q.delete();
      end else if (q.size() == 0) begin
        chk("idle_valid", int'(valid_o), 0);
        chk("idle_ready", int'(ready_o), 0);
        chk("idle_start", int'(start_o), 0);
        chk("idle_last", int'(last_o), 0);
        chk("idle_data", int'(data_o), 0);
        chk("idle_len", int'(len_o), 0);
        if (valid_i && start_i) begin
          build(int'(plen_i));
          ulen_exp = int'(plen_i) + 8;
          ulen_ok = 1;
        end
      end else begin
        e = q[0];
        if (e.hdr) begin
          chk("hdr_valid", int'(valid_o), 1);
          chk("hdr_ready", int'(ready_o), 0);
          chk("hdr_start", int'(start_o), int'(e.st));
          chk("hdr_last", int'(last_o), 0);
          chk("hdr_len", int'(len_o), 2);
          chk("hdr_data", int'(data_o), int'(e.d));
          if (ready_i) void'(q.pop_front());
        end else begin
          chk("pay_valid", int'(valid_o), int'(valid_i));
          chk("pay_ready", int'(ready_o), int'(ready_i));
          if (valid_i) begin
            ed = e.d;
            ad = data_o;
            chk("pay_start", int'(start_o), 0);
            chk("pay_last", int'(last_o), int'(e.la));
            chk("pay_len", int'(len_o), e.l);
            chk("pay_data_hi", int'(ad[15:8]), int'(ed[15:8]));
            if (e.l == 2) chk("pay_data_lo", int'(ad[7:0]), int'(ed[7:0]));
            if (ready_i) begin
              void'(q.pop_front());
              if (e.la) q.delete();
            end
          end
        end
      end
    end
    front_hdr = (q.size() > 0 && q[0].hdr) ? q[0].hi : -1;
    front_pay = (q.size() > 0 && !q[0].hdr);
  end

  task automatic run_frame(input int plen, input int rdy_pct, input int bub_pct,
                           input int bub_k, input int cancel_k, input int rst_h,
                           input int hold_n, input bit fixed);
    int nb;
    int k;
    int cyc;
    int hold;
    bit bubbled;
    bit done;
    nb = (plen + 1) / 2;
    k = 0; cyc = 0; hold = hold_n; bubbled = 0; done = 0;
    if (!fixed) begin
      for (int i = 0; i < 64; i++) begin
        pay_d[i] = 16'($urandom);
        pay_l[i] = 2;
      end
      if ((plen % 2) == 1 && nb <= 64) pay_l[nb-1] = int'($urandom_range(1, 2));
    end
    plen_i = 16'(plen);
    while (k < nb && !done) begin
      cancel_i = 1'b0;
      nreset   = 1'b1;
      valid_i  = 1'b1;
      start_i  = (k == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      data_i   = pay_d[k];
      len_i    = 2'(pay_l[k]);
      if (k > 0 && ((k == bub_k && !bubbled) ||
                    int'($urandom_range(0, 99)) < bub_pct)) begin
        valid_i = 1'b0;
        if (k == bub_k) bubbled = 1;
      end
      ready_i = (int'($urandom_range(0, 99)) < rdy_pct);
      if (front_hdr == 2 && hold > 0) begin
        ready_i = 1'b0;
        hold--;
      end
      if (cancel_k == k && front_pay && valid_i) begin
        cancel_i = 1'b1;
        done = 1;
      end
      if (rst_h >= 0 && front_hdr == rst_h) begin
        nreset = 1'b0;
        done = 1;
      end
      @(posedge clk); #1;
      if (took) k++;
      cyc++;
      if (cyc > 3000) begin
        n_chk++;
        n_fail++;
        $display("FAIL frame_timeout: got %0d beats expected %0d", k, nb);
        done = 1;
      end
    end
    valid_i = 1'b0; start_i = 1'b0; cancel_i = 1'b0; nreset = 1'b1;
  endtask

  task automatic idle_noise(input int n);
    for (int i = 0; i < n; i++) begin
      valid_i  = 1'($urandom_range(0, 1));
      cancel_i = ($urandom_range(0, 3) == 0);
      start_i  = cancel_i & valid_i;
      data_i   = 16'($urandom);
      ready_i  = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    valid_i = 1'b0; start_i = 1'b0; cancel_i = 1'b0;
  endtask

  task automatic count_log(input logic [15:0] d, output int n_d,
                           output int n_st, output int n_la);
    n_d = 0; n_st = 0; n_la = 0;
    foreach (log_q[i]) begin
      if (log_q[i].d == d) n_d++;
      if (log_q[i].st) n_st++;
      if (log_q[i].la) n_la++;
    end
  endtask

  initial begin
    int          nd, ns, nl;
    logic [15:0] exp1[6];
    logic [15:0] hi;
    exp1[0] = 16'h4696; exp1[1] = 16'h4696; exp1[2] = 16'h000C;
    exp1[3] = 16'h0000; exp1[4] = 16'hAABB; exp1[5] = 16'hCCDD;

    nreset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", int'(valid_o), 0);
    chk("rst_ready", int'(ready_o), 0);
    chk("rst_start", int'(start_o), 0);
    chk("rst_last", int'(last_o), 0);
    chk("rst_data", int'(data_o), 0);
    chk("rst_len", int'(len_o), 0);
    nreset = 1'b1;
    @(posedge clk); #1;

    pay_d[0] = 16'hAABB; pay_l[0] = 2;
    pay_d[1] = 16'hCCDD; pay_l[1] = 2;
    log_q.delete();
    run_frame(4, 100, 0, -1, -1, -1, 0, 1);
    chk("t1_beats", log_q.size(), 6);
    for (int i = 0; i < 6 && i < log_q.size(); i++)
      chk("t1_word", int'(log_q[i].d), int'(exp1[i]));
    if (log_q.size() == 6) begin
      chk("t1_start", int'(log_q[0].st), 1);
      chk("t1_last", int'(log_q[5].la), 1);
      chk("t1_last_len", log_q[5].l, 2);
      chk("t1_rdy_hdr", int'(log_q[3].rdy), 0);
      chk("t1_rdy_p0", int'(log_q[4].rdy), 1);
      chk("t1_rdy_p1", int'(log_q[5].rdy), 1);
    end
    chk("t1_udp_len", int'(udp_len_o), 12);
    idle_noise(3);

    pay_d[0] = 16'hAABB; pay_l[0] = 2;
    pay_d[1] = 16'hCC00; pay_l[1] = 1;
    log_q.delete();
    run_frame(3, 100, 0, -1, -1, -1, 0, 1);
    chk("t2_beats", log_q.size(), 6);
    if (log_q.size() == 6) begin
      chk("t2_lenword", int'(log_q[2].d), 16'h000B);
      hi = log_q[5].d;
      chk("t2_tail_byte", int'(hi[15:8]), 8'hCC);
      chk("t2_tail_len", log_q[5].l, 1);
      chk("t2_tail_last", int'(log_q[5].la), 1);
    end
    chk("t2_idle", int'(valid_o), 0);

    pay_d[0] = 16'h1234; pay_l[0] = 2;
    pay_d[1] = 16'h5678; pay_l[1] = 2;
    log_q.delete();
    run_frame(4, 100, 0, -1, -1, -1, 3, 1);
    count_log(16'h000C, nd, ns, nl);
    chk("t3_hold_len", nd, 4);
    chk("t3_start_once", ns, 1);
    chk("t3_beats", log_q.size(), 9);

    pay_d[0] = 16'h1111; pay_l[0] = 2;
    pay_d[1] = 16'h2222; pay_l[1] = 2;
    pay_d[2] = 16'h3333; pay_l[2] = 2;
    log_q.delete();
    run_frame(6, 100, 0, 1, -1, -1, 0, 1);
    count_log(16'h3333, nd, ns, nl);
    chk("t4_beats", log_q.size(), 7);
    chk("t4_last_once", nl, 1);
    if (log_q.size() == 7) chk("t4_last_at_end", int'(log_q[6].la), 1);

    log_q.delete();
    run_frame(6, 100, 0, -1, 0, -1, 0, 0);
    chk("t5_cancel_beats", log_q.size(), 4);
    chk("t5_idle_after", int'(valid_o), 0);
    log_q.delete();
    run_frame(2, 100, 0, -1, -1, -1, 0, 0);
    chk("t5_clean_beats", log_q.size(), 5);
    if (log_q.size() == 5) chk("t5_clean_last", int'(log_q[4].la), 1);

    log_q.delete();
    run_frame(6, 100, 0, -1, -1, 1, 0, 0);
    chk("t6_rst_valid", int'(valid_o), 0);
    chk("t6_rst_ready", int'(ready_o), 0);
    chk("t6_beats_before", log_q.size(), 1);
    log_q.delete();
    run_frame(1, 100, 0, -1, -1, -1, 0, 0);
    chk("t6_beats", log_q.size(), 5);
    if (log_q.size() == 5) begin
      chk("t6_lenword", int'(log_q[2].d), 16'h0009);
      chk("t6_tail_len", log_q[4].l, 1);
      chk("t6_tail_last", int'(log_q[4].la), 1);
    end

    log_q.delete();
    run_frame(65527, 100, 0, -1, 0, -1, 0, 0);
    if (log_q.size() >= 3) chk("max_lenword", int'(log_q[2].d), 16'hFFFF);
    else chk("max_beats", log_q.size(), 4);

    for (int f = 0; f < 40; f++) begin
      int plen;
      int nbf;
      int ck;
      plen = int'($urandom_range(1, 100));
      nbf  = (plen + 1) / 2;
      ck   = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, nbf - 1)) : -1;
      run_frame(plen, int'($urandom_range(50, 100)), 20, -1, ck, -1,
                int'($urandom_range(0, 2)), 0);
      idle_noise(int'($urandom_range(0, 4)));
    end

    repeat (3) @(posedge clk);
    #1;
    chk("model_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/udp_tx.md
Name: udp_tx

Overview:
UDP transmit framer. It accepts an application payload stream and prepends the 8-byte UDP header: source port, destination port, length, and checksum fixed at 0, which is legal for IPv4. The header goes out as 4 beats, after which the payload passes through to the IPv4 tx payload interface. The block is the transmit counterpart of udp_rx and uses the same 16-bit big-endian datapath.

Parameters:
DATA_W, 16, datapath width; only 16 is supported.
LEN_W, 2, byte-count field width; legal values are 1 and 2.
PORT_W, 16, port field width.
SRC_PORT, 16'd18070, source port inserted in the header.
DST_PORT, 16'd18070, destination port inserted in the header.
CNT_W, 16, byte counter and length width.

Ports:
clk  in  1  clock
nreset  in  1  synchronous reset, active-low
cancel_i  in  1  abort the current datagram
valid_i  in  1  application beat valid
start_i  in  1  first payload beat of a datagram
data_i  in  DATA_W  payload; data_i[15:8] is the first byte on the wire
len_i  in  LEN_W  valid bytes in the beat (1 or 2)
plen_i  in  CNT_W  payload byte count; sampled with valid_i & start_i in IDLE
ready_o  out  1  application beat consumed (valid_i & ready_o)
ready_i  in  1  downstream accepts the beat
valid_o  out  1  beat valid to IP tx
start_o  out  1  first header beat
last_o  out  1  final beat of the datagram
data_o  out  DATA_W  header or payload word
len_o  out  LEN_W  valid bytes in the output beat
udp_len_o  out  CNT_W  plen+8, stable from the first header beat until the last beat

Behaviour:
- Reset: nreset is synchronous and active-low. On reset, the FSM goes to IDLE and all counters clear. valid_o, start_o, last_o and ready_o are 0; data_o is 0 and len_o is 0 in IDLE.
- FSM states are IDLE, HEAD and DATA, one-hot.
- IDLE:
  - ready_o=0; the start beat is not consumed here.
  - On valid_i & start_i & ~cancel_i: latch plen_i, set udp_len_q = plen_i+8, clear the head and byte counters, and go to HEAD.
  - valid_i without start_i in IDLE is ignored and not consumed.
- HEAD:
  - valid_o=1 and len_o=2; ready_o=0.
  - Beat index h = 0..3 gives data_o = SRC_PORT, DST_PORT, udp_len_q, 16'h0000.
  - start_o=1 only when h=0.
  - h advances only on ready_i; with ready_i=0 the same beat is held stable.
  - When h=3 & ready_i: go to DATA.
- DATA (combinational pass-through, zero latency):
  - valid_o = valid_i; ready_o = ready_i; data_o = data_i; len_o = len_i.
  - A transfer occurs on valid_i & ready_i; on each transfer cnt += len_i.
  - last_o = valid_i & (cnt + len_i >= plen).
  - On a transfer with last_o: go to IDLE.
  - valid_i=0 mid-payload produces a bubble with valid_o=0; no state change.
- Output data_o/len_o/last_o are meaningful only when valid_o=1.
- Byte count arithmetic is CNT_W bits wide. Legal plen is 1..65527, so plen+8 does not overflow.
  - plen=0 or plen>65527 is illegal and is covered by a formal assert.
  - Bytes beyond plen in the final beat are dropped: on the last beat len_o = plen - cnt, e.g. 1 for an odd tail. last_o asserts even if len_i overshoots.
- Odd-length payload: only the final beat may have len_i=1, with the byte in data_i[15:8]; data_o[7:0] is don't-care.
- cancel_i:
  - In any state, the next state is IDLE and counters clear.
  - In the cancel cycle, valid_o and ready_o are forced to 0.
  - No last_o is produced; the downstream IP layer is told separately.
  - cancel_i together with a start beat in IDLE is ignored and the block stays in IDLE.
- Reset mid-frame: immediately IDLE, outputs at reset values, no trailing beats.
- start_i asserted during HEAD or DATA is ignored; the frame continues by count.
- udp_len_o holds its value through IDLE until the next start.

Decomposition:
- Shared package udp_pkg holds:
  - UDP_HEAD_N=8 and UDP_HEAD_BEATS=4;
  - PORT_W=16;
  - DEFAULT_PORT=16'd18070;
  - the head beat index enum (SRC, DST, LEN, CSUM);
  - the FSM state encoding.
- udp_rx migrates to the same package.
- No sub-module: the header mux, counter and FSM stay in one module.

Test Plan:
1. plen=4 with beats 0xAABB/2 and 0xCCDD/2, ready_i=1 -> outputs 0x4696(start), 0x4696, 0x000C, 0x0000, 0xAABB, 0xCCDD(last, len 2). ready_o is high only on the last two cycles; udp_len_o=12.
2. plen=3 with beats 0xAABB/2 and 0xCC00/1 -> length word 0x000B; final beat 0xCC.. with len_o=1 and last_o=1; FSM returns to IDLE.
3. ready_i low for 3 cycles at header beat 2 -> 0x000C is held with valid_o=1 for 4 cycles, start_o is not re-asserted, and the frame is otherwise unchanged.
4. plen=6 with an app bubble (valid_i=0) after the first payload beat -> valid_o=0 for that cycle; last_o only on the third payload beat.
5. cancel_i on the first payload beat of plen=6 -> valid_o and ready_o are 0 that cycle; IDLE next cycle. A following start with plen=2 produces a clean 5-beat frame.
6. nreset low during header beat 1 -> next cycle valid_o=0 and ready_o=0 in IDLE. A new frame with plen=1 gives a final beat with len_o=1, preceded by length word 0x0009.
